// File: rtl/hx8352_window_scheduler.sv
// hx8352_window_scheduler: turns a rectangular window request into the hx8352
// strobe sequence (eight index/value pairs for the window registers, then the
// RAM-write index), then streams W*H pixels from a valid/ready source.
module hx8352_window_scheduler #(
    parameter int         COORD_W   = 9,
    parameter int         H_RES     = 240,
    parameter int         V_RES     = 400,
    parameter logic [7:0] RAMWR_REG = 8'h22
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] y1,
    output logic               req_ack,
    output logic               req_err,
    input  logic [15:0]        pix_data,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic               lcd_init_done,
    input  logic               lcd_busy,
    output logic [15:0]        lcd_cmd,
    output logic               lcd_cmd_step,
    output logic [15:0]        lcd_data,
    output logic               lcd_data_step,
    output logic               active,
    output logic               done
);

    localparam int CNT_W = 18;
    localparam int EXT_W = COORD_W + 1;
    localparam logic [EXT_W-1:0] H_LIM = EXT_W'(H_RES);
    localparam logic [EXT_W-1:0] V_LIM = EXT_W'(V_RES);

    // WAIT_A ignores lcd_busy for one cycle after a strobe so the controller
    // has time to raise it; WAIT_B then holds until the controller is free.
    typedef enum logic [2:0] {
        S_IDLE, S_IDX, S_VAL, S_RAMWR, S_PIX, S_WAIT_A, S_WAIT_B, S_FIN
    } state_t;

    state_t             state;
    state_t             resume;
    logic [3:0]         seq;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   total;
    logic [COORD_W-1:0] cx0, cx1, cy0, cy1;

    logic               accept_go;
    logic               bad_window;
    logic               transfer;
    logic [EXT_W-1:0]   width;
    logic [EXT_W-1:0]   height;
    logic [CNT_W-1:0]   area;

    // Byte k of the window register block: k[2:1] picks x0/x1/y0/y1,
    // k[0]=0 is the high byte of the zero-extended coordinate.
    function automatic logic [7:0] pair_byte(input logic [2:0] k,
                                             input logic [COORD_W-1:0] a,
                                             input logic [COORD_W-1:0] b,
                                             input logic [COORD_W-1:0] c,
                                             input logic [COORD_W-1:0] d);
        logic [15:0] ext;
        case (k[2:1])
            2'd0:    ext = 16'(a);
            2'd1:    ext = 16'(b);
            2'd2:    ext = 16'(c);
            default: ext = 16'(d);
        endcase
        return k[0] ? ext[7:0] : ext[15:8];
    endfunction

    assign accept_go  = req & lcd_init_done & ~lcd_busy;
    assign bad_window = (x0 > x1) | (y0 > y1) |
                        ({1'b0, x1} >= H_LIM) | ({1'b0, y1} >= V_LIM);
    assign width      = {1'b0, x1} - {1'b0, x0} + EXT_W'(1);
    assign height     = {1'b0, y1} - {1'b0, y0} + EXT_W'(1);
    assign area       = CNT_W'(width) * CNT_W'(height);

    // The source sees ready only in PIX with the controller free; the strobe
    // for an accepted pixel is launched by the same edge that completes it.
    assign pix_ready  = (state == S_PIX) & ~lcd_busy;
    assign transfer   = pix_ready & pix_valid;

    // Window geometry is latched once at accept and held for the whole window.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && accept_go && !bad_window) begin
            cx0   <= x0;
            cx1   <= x1;
            cy0   <= y0;
            cy1   <= y1;
            total <= area;
        end
    end

    // Main sequencer: accept, register pairs, RAM-write index, pixel stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            resume        <= S_IDLE;
            seq           <= '0;
            count         <= '0;
            req_ack       <= 1'b0;
            req_err       <= 1'b0;
            lcd_cmd       <= 16'h0000;
            lcd_cmd_step  <= 1'b0;
            lcd_data      <= 16'h0000;
            lcd_data_step <= 1'b0;
            active        <= 1'b0;
            done          <= 1'b0;
        end else begin
            req_ack       <= 1'b0;
            req_err       <= 1'b0;
            lcd_cmd_step  <= 1'b0;
            lcd_data_step <= 1'b0;
            done          <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_go) begin
                        if (bad_window) begin
                            req_err <= 1'b1;
                        end else begin
                            req_ack <= 1'b1;
                            active  <= 1'b1;
                            seq     <= '0;
                            count   <= '0;
                            state   <= S_IDX;
                        end
                    end
                end
                S_IDX: begin
                    if (!lcd_busy) begin
                        lcd_cmd      <= {8'h00, 8'h02 + {5'b00000, seq[3:1]}};
                        lcd_cmd_step <= 1'b1;
                        seq          <= seq + 4'd1;
                        resume       <= S_VAL;
                        state        <= S_WAIT_A;
                    end
                end
                S_VAL: begin
                    if (!lcd_busy) begin
                        lcd_data      <= {8'h00, pair_byte(seq[3:1], cx0, cx1, cy0, cy1)};
                        lcd_data_step <= 1'b1;
                        seq           <= seq + 4'd1;
                        resume        <= (seq == 4'd15) ? S_RAMWR : S_IDX;
                        state         <= S_WAIT_A;
                    end
                end
                S_RAMWR: begin
                    if (!lcd_busy) begin
                        lcd_cmd      <= {8'h00, RAMWR_REG};
                        lcd_cmd_step <= 1'b1;
                        resume       <= S_PIX;
                        state        <= S_WAIT_A;
                    end
                end
                S_PIX: begin
                    if (transfer) begin
                        lcd_data      <= pix_data;
                        lcd_data_step <= 1'b1;
                        count         <= count + CNT_W'(1);
                        resume        <= (count + CNT_W'(1) == total) ? S_FIN : S_PIX;
                        state         <= S_WAIT_A;
                    end
                end
                S_WAIT_A: state <= S_WAIT_B;
                S_WAIT_B: begin
                    if (!lcd_busy) state <= resume;
                end
                S_FIN: begin
                    done   <= 1'b1;
                    active <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hx8352_window_scheduler.sv
// tb_hx8352_window_scheduler: drives window requests, a busy-after-strobe
// controller model and a random-gap pixel source; every strobe is matched
// against a queue of expected strobes built from the window corners.
module tb_hx8352_window_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [8:0]  x0 = '0, x1 = '0, y0 = '0, y1 = '0;
    logic        req_ack, req_err;
    logic [15:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        lcd_init_done = 1'b1;
    logic        lcd_busy = 1'b0;
    logic [15:0] lcd_cmd, lcd_data;
    logic        lcd_cmd_step, lcd_data_step;
    logic        active, done;

    hx8352_window_scheduler dut (
        .clk(clk), .rst(rst), .req(req),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .req_ack(req_ack), .req_err(req_err),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .lcd_init_done(lcd_init_done), .lcd_busy(lcd_busy),
        .lcd_cmd(lcd_cmd), .lcd_cmd_step(lcd_cmd_step),
        .lcd_data(lcd_data), .lcd_data_step(lcd_data_step),
        .active(active), .done(done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // expected strobes: {is_cmd, value}
    logic [16:0] exp_q[$];
    int  busy_len = 1, bcnt = 0;
    bit  src_en = 0, consumed = 0;
    int  cyc = 0, last_strobe = -10, hdr_left = 0, pix_strobes = 0;
    int  done_cnt = 0, ack_cnt = 0, err_cnt = 0, first_pix_cyc = 0, ack_cyc = 0;
    bit  prev_busy = 0;

    // controller busy model and pixel source, updated just after each edge
    always @(posedge clk) begin
        #1;
        if (bcnt > 0) begin lcd_busy = 1'b1; bcnt--; end
        else lcd_busy = 1'b0;
        if (lcd_cmd_step || lcd_data_step) bcnt = busy_len;
        if (!pix_valid || consumed) begin
            pix_valid = src_en && ($urandom_range(3) != 0);
            pix_data  = 16'($urandom);
        end
        consumed = 0;
    end

    // strobe monitor and protocol rules
    always @(negedge clk) begin
        logic [16:0] obs, e;
        cyc++;
        if (rst) begin
            if (lcd_busy) check_val("ready_while_busy", 32'(pix_ready), 0);
            if (lcd_cmd_step || lcd_data_step) begin
                check_val("strobe_after_busy", 32'(prev_busy), 0);
                check_val("strobe_spacing", 32'((cyc - last_strobe) >= 2), 1);
                last_strobe = cyc;
                if (lcd_cmd_step && lcd_data_step) check_val("two_strobes", 32'(lcd_data_step), 0);
                obs = lcd_cmd_step ? {1'b1, lcd_cmd} : {1'b0, lcd_data};
                check_val("strobe_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (hdr_left > 0) begin
                        check_val("header_strobe", 32'(obs), 32'(e));
                        hdr_left--;
                    end else begin
                        check_val("pixel_strobe", 32'(obs), 32'(e));
                        pix_strobes++;
                        if (pix_strobes == 1) first_pix_cyc = cyc;
                    end
                end
            end
            if (pix_valid && pix_ready) begin
                exp_q.push_back({1'b0, pix_data});
                consumed = 1;
            end
            if (done) done_cnt++;
            if (req_ack) begin ack_cnt++; ack_cyc = cyc; end
            if (req_err) err_cnt++;
        end
        prev_busy = lcd_busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic queue_header(input int a, input int b, input int c, input int d);
        int v[4];
        v = '{a, b, c, d};
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({1'b1, 16'(2 + k)});
            exp_q.push_back({1'b0, 16'((k % 2 == 0) ? (v[k/2] >> 8) : (v[k/2] & 255))});
        end
        exp_q.push_back({1'b1, 16'h0022});
        hdr_left = 17;
        pix_strobes = 0;
    endtask

    task automatic send_req(input int a, input int b, input int c, input int d,
                            input bit hold, output bit acked, output bit errd);
        x0 = 9'(a); x1 = 9'(b); y0 = 9'(c); y1 = 9'(d);
        req = 1'b1;
        acked = 0; errd = 0;
        for (int i = 0; i < 40 && !acked && !errd; i++) begin
            @(negedge clk);
            acked = req_ack;
            errd  = req_err;
        end
        if (acked) check_val("active_at_ack", 32'(active), 1);
        if (errd)  check_val("active_at_err", 32'(active), 0);
        if (!hold || !acked) req = 1'b0;
        // latched corners: later input changes must not matter
        x0 = 9'($urandom); x1 = 9'($urandom); y0 = 9'($urandom); y1 = 9'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        req = 1'b0;
        if (seen) begin
            check_val("active_at_done", 32'(active), 0);
            @(negedge clk);
            check_val("done_pulse_width", 32'(done), 0);
        end
    endtask

    task automatic run_window(input int a, input int b, input int c, input int d,
                              input int bl, input bit hold);
        bit ok, er, seen;
        int area, a0;
        area = (b - a + 1) * (d - c + 1);
        busy_len = bl;
        queue_header(a, b, c, d);
        src_en = 1;
        a0 = ack_cnt;
        send_req(a, b, c, d, hold, ok, er);
        check_val("req_ack", 32'(ok), 1);
        wait_done((area + 17) * (bl + 12) + 200, seen);
        check_val("done_seen", 32'(seen), 1);
        check_val("pixel_count", 32'(pix_strobes), 32'(area));
        check_val("queue_drained", 32'(exp_q.size()), 0);
        check_val("single_ack", 32'(ack_cnt - a0), 1);
        src_en = 0;
        tick(3);
    endtask

    task automatic reset_midway();
        int d0;
        @(posedge clk); #1;
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        check_val("reset_ctrl_zero", 32'({req_ack, req_err, pix_ready, lcd_cmd_step,
                                           lcd_data_step, active, done}), 0);
        check_val("reset_bus_zero", {lcd_cmd, lcd_data}, 0);
        tick(3);
        exp_q.delete();
        hdr_left = 0;
        rst = 1'b1;
        tick(5);
        check_val("no_done_after_reset", 32'(done_cnt - d0), 0);
        check_val("idle_after_reset", 32'(active), 0);
    endtask

    initial begin
        bit ok, er, seen, reached;
        int a, b, c, d, a0, e0;

        // reset state
        tick(3);
        check_val("rst_ctrl_zero", 32'({req_ack, req_err, pix_ready, lcd_cmd_step,
                                         lcd_data_step, active, done}), 0);
        check_val("rst_bus_zero", {lcd_cmd, lcd_data}, 0);
        rst = 1'b1;
        tick(3);

        // 2x2 window, busy for 1 cycle after each strobe, req held during transfer
        run_window(0, 1, 0, 1, 1, 1);
        check_val("first_pixel_latency", 32'((first_pix_cyc - ack_cyc) >= 34), 1);

        // rejected windows: no strobes (exp_q is empty), active stays low
        exp_q.delete(); hdr_left = 0;
        send_req(0, 240, 0, 10, 0, ok, er);
        check_val("err_x1_hres", 32'({ok, er}), 32'b01);
        tick(5);
        send_req(0, 10, 5, 4, 0, ok, er);
        check_val("err_y0_gt_y1", 32'({ok, er}), 32'b01);
        tick(5);
        send_req(6, 5, 0, 0, 0, ok, er);
        check_val("err_x0_gt_x1", 32'({ok, er}), 32'b01);
        tick(5);
        send_req(0, 0, 0, 400, 0, ok, er);
        check_val("err_y1_vres", 32'({ok, er}), 32'b01);
        tick(5);
        check_val("active_after_errs", 32'(active), 0);

        // long busy after each strobe
        run_window(0, 1, 0, 0, 20, 0);

        // 1x1 window at the far corner
        run_window(239, 239, 399, 399, 2, 0);

        // random small windows with random busy length
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(232); b = a + $urandom_range(7);
            c = $urandom_range(392); d = c + $urandom_range(7);
            run_window(a, b, c, d, $urandom_range(3), 0);
        end

        // full-width band with random source gaps
        run_window(0, 239, 0, 19, 1, 0);

        // full screen: header and first pixels, then abandoned by reset
        busy_len = 0;
        queue_header(0, 239, 0, 399);
        src_en = 1;
        send_req(0, 239, 0, 399, 0, ok, er);
        check_val("full_screen_ack", 32'(ok), 1);
        reached = 0;
        for (int i = 0; i < 3000 && !reached; i++) begin
            @(negedge clk);
            if (pix_strobes >= 40) reached = 1;
        end
        check_val("full_screen_streaming", 32'(reached), 1);
        check_val("full_screen_header_done", 32'(hdr_left), 0);
        reset_midway();

        // reset at pixel 3, then a new window restarts at index 02
        busy_len = 1;
        queue_header(10, 19, 3, 5);
        src_en = 1;
        send_req(10, 19, 3, 5, 0, ok, er);
        check_val("pre_reset_ack", 32'(ok), 1);
        reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge clk);
            if (pix_strobes >= 3) reached = 1;
        end
        check_val("reached_pixel3", 32'(reached), 1);
        reset_midway();
        run_window(0, 2, 0, 1, 1, 0);

        // request held off while controller init is incomplete
        lcd_init_done = 1'b0;
        busy_len = 1;
        queue_header(3, 4, 7, 8);
        src_en = 1;
        a0 = ack_cnt; e0 = err_cnt;
        x0 = 9'd3; x1 = 9'd4; y0 = 9'd7; y1 = 9'd8;
        req = 1'b1;
        tick(15);
        check_val("held_off_ack", 32'(ack_cnt - a0), 0);
        check_val("held_off_err", 32'(err_cnt - e0), 0);
        lcd_init_done = 1'b1;
        ok = 0;
        for (int i = 0; i < 3 && !ok; i++) begin
            @(negedge clk);
            ok = req_ack;
        end
        req = 1'b0;
        check_val("ack_after_init", 32'(ok), 1);
        wait_done(1000, seen);
        check_val("init_window_done", 32'(seen), 1);
        check_val("init_window_pixels", 32'(pix_strobes), 4);
        src_en = 0;
        tick(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
